// File: rtl/s3_trit_packer.sv
// s3_trit_packer: packs mod-q ternary coefficients {0,1,q-1} five trits per byte (base 3).
// Optional PACK_ERR_CHECK_EN: full-width coefficient check with sticky err output.
module s3_trit_packer #(
    parameter int N_COEF  = 701,
    parameter int Q_WIDTH = 13
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Q_WIDTH-1:0] in_coef,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_byte,
    output logic               out_last
`ifdef PACK_ERR_CHECK_EN
    ,
    output logic               err
`endif
);
    localparam int CW = $clog2(N_COEF);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_COEF - 1);

    logic [7:0]    acc;
    logic [2:0]    trit_idx;
    logic [CW-1:0] coef_cnt;
    logic [1:0]    trit;
    logic [7:0]    w, tw, sum;
    logic          fire, last, close;

`ifdef PACK_ERR_CHECK_EN
    logic bad;
    assign trit = in_coef == Q_WIDTH'(1) ? 2'd1 : in_coef == {Q_WIDTH{1'b1}} ? 2'd2 : 2'd0;
    assign bad  = in_coef != '0 && in_coef != Q_WIDTH'(1) && in_coef != {Q_WIDTH{1'b1}};
`else
    logic unused_bits;
    assign trit        = {in_coef[Q_WIDTH-1], in_coef[0] & ~in_coef[Q_WIDTH-1]};
    assign unused_bits = ^in_coef[Q_WIDTH-2:1];
`endif

    assign in_ready = !out_valid || out_ready;
    assign fire     = in_valid && in_ready;
    assign last     = coef_cnt == LAST_IDX;
    assign close    = trit_idx == 3'd4 || last;
    assign w        = trit_idx == 3'd0 ? 8'd1 : trit_idx == 3'd1 ? 8'd3 :
                      trit_idx == 3'd2 ? 8'd9 : trit_idx == 3'd3 ? 8'd27 : 8'd81;
    // trit 2 is just the weight doubled; 2*81 still fits in 8 bits
    assign tw       = trit[1] ? {w[6:0], 1'b0} : trit[0] ? w : 8'd0;
    assign sum      = acc + tw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            trit_idx  <= '0;
            coef_cnt  <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            out_last  <= 1'b0;
`ifdef PACK_ERR_CHECK_EN
            err       <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (fire) begin
                coef_cnt <= last ? '0 : coef_cnt + 1'b1;
`ifdef PACK_ERR_CHECK_EN
                err      <= err | bad;
`endif
                if (close) begin
                    out_byte  <= sum;
                    out_valid <= 1'b1;
                    out_last  <= last;
                    acc       <= '0;
                    trit_idx  <= '0;
                end else begin
                    acc      <= sum;
                    trit_idx <= trit_idx + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_s3_trit_packer.sv
// tb_s3_trit_packer: directed vector bench for the S3 trit packer.
module tb_s3_trit_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [12:0] in_coef = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        out_last;
`ifdef PACK_ERR_CHECK_EN
    logic        err;
`endif

    s3_trit_packer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_coef(in_coef), .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .out_last(out_last)
`ifdef PACK_ERR_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0][12:0] c;
        logic [7:0]       b;
    } vec_t;

    vec_t       tbl[7];
    logic [8:0] q[$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         stalls = 0;

    always @(negedge clk)
        if (rst_n && out_valid && out_ready) q.push_back({out_last, out_byte});

    function automatic vec_t mk(int c0, int c1, int c2, int c3, int c4, int b);
        vec_t v;
        v.c[0] = 13'(c0); v.c[1] = 13'(c1); v.c[2] = 13'(c2);
        v.c[3] = 13'(c3); v.c[4] = 13'(c4); v.b = 8'(b);
        return v;
    endfunction

    function automatic int trit_of(logic [12:0] c);
        return c == 13'd8191 ? 2 : c == 13'd1 ? 1 : 0;
    endfunction

    function automatic logic [12:0] pat(int i);
        int k;
        k = (i * 7 + i / 3) % 3;
        return k == 0 ? 13'd0 : k == 1 ? 13'd1 : 13'd8191;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(logic [12:0] c);
        int n = 0;
        in_valid = 1'b1;
        in_coef  = c;
        @(negedge clk);
        if (!in_ready) stalls++;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic get(output logic [8:0] v);
        int n = 0;
        while (q.size() == 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() == 0) begin
            chk("get_timeout", 0, 1);
            v = 'x;
        end else v = q.pop_front();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_out_last", out_last, 0);
`ifdef PACK_ERR_CHECK_EN
        chk("rst_err", err, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
    endtask

    initial begin
        logic [8:0] v;
        int exp_b[142];
        tbl[0] = mk(1, 8191, 0, 1, 1, 8'h73);
        tbl[1] = mk(8191, 8191, 8191, 8191, 8191, 8'hF2);
        tbl[2] = mk(0, 0, 0, 0, 0, 8'h00);
        tbl[3] = mk(1, 1, 1, 1, 1, 8'h79);
        tbl[4] = mk(0, 0, 0, 0, 1, 8'h51);
        tbl[5] = mk(8191, 0, 0, 0, 0, 8'h02);
        tbl[6] = mk(0, 8191, 1, 0, 8191, 8'hB1);

        #1;
        do_reset();
        for (int t = 0; t < 7; t++) begin
            for (int j = 0; j < 5; j++) send(tbl[t].c[j]);
            get(v);
            chk($sformatf("tbl%0d_byte", t), v[7:0], tbl[t].b);
            chk($sformatf("tbl%0d_last", t), v[8], 0);
        end

        // full polynomial then the start of the next, streamed without gaps
        do_reset();
        for (int g = 0; g < 142; g++) exp_b[g] = 0;
        for (int i = 0; i < 701; i++) begin
            logic [12:0] c;
            int p;
            c = i == 700 ? 13'd8191 : pat(i);
            p = 1;
            for (int j = 0; j < i % 5; j++) p *= 3;
            exp_b[i / 5] += trit_of(c) * p;
        end
        exp_b[141] = 8'h73;
        stalls = 0;
        for (int i = 0; i < 706; i++)
            send(i < 700 ? pat(i) : i == 700 ? 13'd8191 : tbl[0].c[i - 701]);
        chk("stream_stalls", stalls, 0);
        chk("byte141_model", exp_b[140], 2);
        for (int g = 0; g < 142; g++) begin
            get(v);
            chk($sformatf("poly_b%0d", g), v[7:0], exp_b[g][7:0]);
            chk($sformatf("poly_l%0d", g), v[8], g == 140);
        end

        // backpressure: byte held, input blocked, nothing lost
        out_ready = 1'b0;
        send(13'd1); send(13'd1); send(13'd0); send(13'd0); send(13'd0);
        in_valid = 1'b1;
        in_coef  = 13'd8191;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_byte", out_byte, 8'h04);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(13'd8191); send(13'd0); send(13'd0); send(13'd0); send(13'd0);
        get(v);
        chk("stall_a", v, {1'b0, 8'h04});
        get(v);
        chk("stall_b", v, {1'b0, 8'h02});

        // reset mid-group
        send(13'd1); send(13'd1); send(13'd1);
        do_reset();
        send(13'd1); send(13'd0); send(13'd0); send(13'd0); send(13'd0);
        get(v);
        chk("post_rst", v, {1'b0, 8'h01});

`ifdef PACK_ERR_CHECK_EN
        send(13'd5); send(13'd1); send(13'd1); send(13'd1); send(13'd1);
        get(v);
        chk("err_byte", v, {1'b0, 8'h78});
        chk("err_set", err, 1);
        send(13'd1); send(13'd0); send(13'd0); send(13'd0); send(13'd0);
        get(v);
        chk("err_byte2", v, {1'b0, 8'h01});
        chk("err_sticky", err, 1);
        do_reset();
`endif

        repeat (3) @(posedge clk);
        chk("drain_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
